// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers IR/npc and derives execute, writeback and memory controls.
// Optional macro DECODE_STATS_EN adds saturating decode_count/illegal_count outputs.
module lc3_decode #(
  parameter int          DATA_W = 16,
  parameter logic [15:0] NOP_IR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_decode,
  input  logic              flush,
  input  logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] npc_in,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] npc_out,
  output logic [5:0]        E_Control,
  output logic [1:0]        W_Control,
  output logic              Mem_Control,
  output logic              decode_valid,
  output logic              illegal_op
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0]       decode_count,
  output logic [15:0]       illegal_count
`endif
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
    OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRP = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic [5:0] e_ctl;
    logic [1:0] w_ctl;
    logic       mem_ctl;
    logic       illegal;
  } ctl_t;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_PC  = 2'b01;
  localparam logic [1:0] W_MEM = 2'b10;

  opcode_e     opcode;
  ctl_t        dec;
  logic [15:0] ir_d, ir_q, npc_d, npc_q;
  ctl_t        ctl_d, ctl_q;
  logic        valid_d, valid_q;

  assign opcode = opcode_e'(dout[15:12]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_ADD: dec.e_ctl = {2'b00, 2'b00, 1'b0, ~dout[5]};
      OP_AND: dec.e_ctl = {2'b01, 2'b00, 1'b0, ~dout[5]};
      OP_NOT: dec.e_ctl = 6'b100000;
      OP_BR:  dec.e_ctl = 6'b000110;
      OP_JMP: dec.e_ctl = 6'b001100;
      OP_LD:  begin dec.e_ctl = 6'b000110; dec.w_ctl = W_MEM; end
      OP_LDR: begin dec.e_ctl = 6'b001000; dec.w_ctl = W_MEM; end
      OP_LDI: begin dec.e_ctl = 6'b000110; dec.w_ctl = W_MEM; dec.mem_ctl = 1'b1; end
      OP_LEA: begin dec.e_ctl = 6'b000110; dec.w_ctl = W_PC; end
      OP_ST:  dec.e_ctl = 6'b000110;
      OP_STR: dec.e_ctl = 6'b001000;
      OP_STI: begin dec.e_ctl = 6'b000110; dec.mem_ctl = 1'b1; end
      OP_JSR, OP_RTI, OP_RES, OP_TRP: dec.illegal = 1'b1;
      default: dec = '0;
    endcase
  end

  // Priority: flush squashes to a never-taken BR, otherwise capture, otherwise hold.
  always_comb begin
    ir_d    = ir_q;
    npc_d   = npc_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = NOP_IR;
      npc_d   = npc_in;
      ctl_d   = '0;
      valid_d = 1'b0;
    end else if (enable_decode) begin
      ir_d    = dout;
      npc_d   = npc_in;
      ctl_d   = dec;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q    <= '0;
      npc_q   <= '0;
      ctl_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = ctl_q.e_ctl;
  assign W_Control    = ctl_q.w_ctl;
  assign Mem_Control  = ctl_q.mem_ctl;
  assign decode_valid = valid_q;
  assign illegal_op   = ctl_q.illegal;

`ifdef DECODE_STATS_EN
  logic [15:0] decode_count_d, decode_count_q;
  logic [15:0] illegal_count_d, illegal_count_q;
  logic        capture;

  assign capture = enable_decode & ~flush;

  // Counters saturate rather than wrap.
  always_comb begin
    decode_count_d  = decode_count_q;
    illegal_count_d = illegal_count_q;
    if (capture) begin
      if (decode_count_q != 16'hFFFF) decode_count_d = decode_count_q + 16'd1;
      if (dec.illegal && illegal_count_q != 16'hFFFF)
        illegal_count_d = illegal_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decode_count_q  <= '0;
      illegal_count_q <= '0;
    end else begin
      decode_count_q  <= decode_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign decode_count  = decode_count_q;
  assign illegal_count = illegal_count_q;
`endif

endmodule
